// File: rtl/sh_l.sv
// Sequential left-shift unit: debounced init capture, one bit per clock, sticky MSB-loss flag.
// Define SH_L_SAT_EN to saturate the result to all ones when a 1 was shifted out.
module sh_l #(
  parameter int unsigned WIDTH_IN  = 3,
  parameter int unsigned WIDTH_OUT = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  portA,
  input  logic [CNT_W-1:0]     n_sh,
  input  logic                 init_sh_l,
  output logic [WIDTH_OUT-1:0] sal_sh_l,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam int unsigned PadW = WIDTH_OUT - WIDTH_IN;

  logic                 s1_q, s2_q, s3_q;
  logic                 start;
  logic [1:0]           state_q, state_d;
  logic [WIDTH_OUT-1:0] b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_OUT-1:0] sal_q, sal_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH_OUT-1:0] result;

  // Two-flop synchronizer plus one delay stage; start is the rising edge of the synced button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= init_sh_l;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign start = s2_q & ~s3_q;

`ifdef SH_L_SAT_EN
  assign result = ovf_q ? {WIDTH_OUT{1'b1}} : b_q;
`else
  assign result = b_q;
`endif

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sal_d   = sal_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          b_d     = {{PadW{1'b0}}, portA};
          cnt_d   = n_sh;
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          b_d   = {b_q[WIDTH_OUT-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (b_q[WIDTH_OUT-1]) begin
            ovf_d = 1'b1;
          end
        end else begin
          // ovf_q already reflects the final shift here, so saturation sees it.
          sal_d   = result;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      b_q     <= '0;
      cnt_q   <= '0;
      sal_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sal_q   <= sal_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sal_sh_l = sal_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_sh_l.sv
// Directed, table-driven bench for sh_l with hand-computed cycle-exact expectations.
module tb_sh_l;

  logic       clk;
  logic       rst;
  logic [2:0] portA;
  logic [1:0] n_sh;
  logic       init_sh_l;
  logic [3:0] sal_sh_l;
  logic       busy;
  logic       done;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic [3:0] prev_res;

  sh_l dut (
    .clk       (clk),
    .rst       (rst),
    .portA     (portA),
    .n_sh      (n_sh),
    .init_sh_l (init_sh_l),
    .sal_sh_l  (sal_sh_l),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [1:0] n;
    logic [3:0] res_wrap;
    logic [3:0] res_sat;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pick(input logic [3:0] w, input logic [3:0] s);
`ifdef SH_L_SAT_EN
    return s;
`else
    return w;
`endif
  endfunction

  // Press at the next edge (j=0), release after j=1, and check every cycle through return to idle.
  task automatic run_op(input string name, input logic [2:0] a, input logic [1:0] n,
                        input logic [3:0] exp_res, input logic exp_ov);
    int last;
    last = int'(n) + 4;
    portA     = a;
    n_sh      = n;
    init_sh_l = 1'b1;
    for (int j = 0; j <= last; j++) begin
      tick();
      if (j == 1) init_sh_l = 1'b0;
      chk($sformatf("%s busy@%0d", name, j), 32'(busy), 32'((j >= 2) && (j <= int'(n) + 3)));
      chk($sformatf("%s done@%0d", name, j), 32'(done), 32'(j == int'(n) + 3));
      if (j == 2) begin
        chk($sformatf("%s ovf_clr", name), 32'(ovf), 32'd0);
        chk($sformatf("%s sal_hold", name), 32'(sal_sh_l), 32'(prev_res));
      end
      if (j == int'(n) + 3) begin
        chk($sformatf("%s result", name), 32'(sal_sh_l), 32'(exp_res));
        chk($sformatf("%s ovf", name), 32'(ovf), 32'(exp_ov));
      end
    end
    chk($sformatf("%s idle_res", name), 32'(sal_sh_l), 32'(exp_res));
    chk($sformatf("%s idle_ovf", name), 32'(ovf), 32'(exp_ov));
    prev_res = exp_res;
  endtask

  initial begin
    int done_cnt;
    int busy_rise;
    logic busy_prev;

    vecs[0] = '{a: 3'b011, n: 2'd1, res_wrap: 4'b0110, res_sat: 4'b0110, ov: 1'b0};
    vecs[1] = '{a: 3'b101, n: 2'd2, res_wrap: 4'b0100, res_sat: 4'b1111, ov: 1'b1};
    vecs[2] = '{a: 3'b111, n: 2'd0, res_wrap: 4'b0111, res_sat: 4'b0111, ov: 1'b0};
    vecs[3] = '{a: 3'b001, n: 2'd3, res_wrap: 4'b1000, res_sat: 4'b1000, ov: 1'b0};
    vecs[4] = '{a: 3'b111, n: 2'd3, res_wrap: 4'b1000, res_sat: 4'b1111, ov: 1'b1};
    vecs[5] = '{a: 3'b110, n: 2'd1, res_wrap: 4'b1100, res_sat: 4'b1100, ov: 1'b0};
    vecs[6] = '{a: 3'b100, n: 2'd2, res_wrap: 4'b0000, res_sat: 4'b1111, ov: 1'b1};
    vecs[7] = '{a: 3'b000, n: 2'd3, res_wrap: 4'b0000, res_sat: 4'b0000, ov: 1'b0};

    rst = 1'b0;
    portA = 3'b000;
    n_sh = 2'd0;
    init_sh_l = 1'b0;
    prev_res = 4'b0000;
    #1;
    chk("reset sal", 32'(sal_sh_l), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].n,
             pick(vecs[i].res_wrap, vecs[i].res_sat), vecs[i].ov);
    end

    // Second press during an n=3 run must be ignored.
    portA = 3'b001;
    n_sh = 2'd3;
    init_sh_l = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 1) init_sh_l = 1'b0;
      if (j == 2) begin
        init_sh_l = 1'b1;
        portA = 3'b111;
      end
      if (j == 3) init_sh_l = 1'b0;
      if (done) done_cnt++;
    end
    chk("dual done_cnt", 32'(done_cnt), 32'd1);
    chk("dual result", 32'(sal_sh_l), 32'h8);
    chk("dual busy", 32'(busy), 32'd0);
    prev_res = 4'b1000;

    // Asynchronous reset mid-shift with an old result held.
    run_op("pre_rst", 3'b011, 2'd1, 4'b0110, 1'b0);
    portA = 3'b111;
    n_sh = 2'd3;
    init_sh_l = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      tick();
      if (j == 1) init_sh_l = 1'b0;
    end
    chk("mid busy_pre", 32'(busy), 32'd1);
    chk("mid ovf_pre", 32'(ovf), 32'd1);
    chk("mid sal_pre", 32'(sal_sh_l), 32'h6);
    #2 rst = 1'b0;
    #1;
    chk("mid sal_rst", 32'(sal_sh_l), 32'd0);
    chk("mid busy_rst", 32'(busy), 32'd0);
    chk("mid ovf_rst", 32'(ovf), 32'd0);
    chk("mid done_rst", 32'(done), 32'd0);
    tick();
    #2 rst = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("mid no_done", 32'(done_cnt), 32'd0);
    prev_res = 4'b0000;
    run_op("post_rst", 3'b101, 2'd2, pick(4'b0100, 4'b1111), 1'b1);

    // Button held for 20 cycles yields one operation.
    portA = 3'b011;
    n_sh = 2'd1;
    init_sh_l = 1'b1;
    done_cnt = 0;
    busy_rise = 0;
    busy_prev = busy;
    for (int j = 0; j < 26; j++) begin
      tick();
      if (j == 19) init_sh_l = 1'b0;
      if (done) done_cnt++;
      if (busy && !busy_prev) busy_rise++;
      busy_prev = busy;
    end
    chk("hold done_cnt", 32'(done_cnt), 32'd1);
    chk("hold captures", 32'(busy_rise), 32'd1);
    chk("hold result", 32'(sal_sh_l), 32'h6);
    prev_res = 4'b0110;
    run_op("repress", 3'b110, 2'd1, 4'b1100, 1'b0);

    // Button already high when reset releases: capture on the 3rd edge.
    rst = 1'b0;
    init_sh_l = 1'b1;
    portA = 3'b010;
    n_sh = 2'd1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rel busy@1", 32'(busy), 32'd0);
    tick();
    chk("rel busy@2", 32'(busy), 32'd0);
    tick();
    chk("rel busy@3", 32'(busy), 32'd1);
    init_sh_l = 1'b0;
    tick();
    chk("rel done@4", 32'(done), 32'd0);
    tick();
    chk("rel done@5", 32'(done), 32'd1);
    chk("rel result", 32'(sal_sh_l), 32'h4);
    tick();
    chk("rel idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
